// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, fetch state encoding and PC increment helper
package cpu_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'hFFFF_FFFC;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // Wraps modulo 2^XLEN so RESET_PC+4 lands on address 0.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: PC register, imem, hazard/redirect and IF/ID signals
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] pc_addr;
  logic [XLEN-1:0] next_pc;
  logic            pc_write;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            id_stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [31:0]     ifid_instr;
  logic [XLEN-1:0] ifid_pc4;
  logic            ifid_valid;

  modport master (
    input  pc_addr, imem_ack, imem_rdata, id_stall, redirect_valid, redirect_target,
    output next_pc, pc_write, imem_req, imem_addr, ifid_instr, ifid_pc4, ifid_valid
  );

  modport slave (
    output pc_addr, imem_ack, imem_rdata, id_stall, redirect_valid, redirect_target,
    input  next_pc, pc_write, imem_req, imem_addr, ifid_instr, ifid_pc4, ifid_valid
  );

endinterface

// File: rtl/fetch_unit_if_id_latch.sv
// rtl/fetch_unit_if_id_latch.sv - IF/ID pipeline register; priority flush > load > hold > bubble
module if_id_latch
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic            hold_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc4_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc4_o,
  output logic            valid_o
);

  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc4_d   = pc4_i;
      valid_d = 1'b1;
    end else if (!hold_i) begin
      // ID consumed the entry and nothing new arrived: insert a bubble
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage; FETCH_PERF_CNT_EN adds fetch/stall counters
module fetch_unit
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;

  logic [XLEN-1:0] pc4;
  logic            ack_req;
  logic            keep;
  logic            ld_load;
  logic [31:0]     ld_instr;
  logic [XLEN-1:0] ld_pc4;

  assign pc4     = pc_plus4(bus.pc_addr);
  assign ack_req = (state_q == REQ) && bus.imem_ack;
  // An ack is discarded when a redirect is current or still pending
  assign keep    = ack_req && !bus.redirect_valid && !pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      skid_instr_q  <= NOP_INSTR;
      skid_pc4_q    <= '0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc4_q    <= skid_pc4_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (bus.imem_ack) begin
          pend_d = 1'b0;
          if (keep && bus.id_stall) begin
            state_d      = HOLD;
            skid_instr_d = bus.imem_rdata;
            skid_pc4_d   = pc4;
          end
        end else if (bus.redirect_valid) begin
          pend_d        = 1'b1;
          pend_target_d = bus.redirect_target;
        end
      end
      HOLD: if (bus.redirect_valid || !bus.id_stall) state_d = REQ;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    bus.imem_req  = 1'b0;
    bus.imem_addr = bus.pc_addr;
    bus.pc_write  = 1'b0;
    bus.next_pc   = pc4;
    ld_load       = 1'b0;
    ld_instr      = bus.imem_rdata;
    ld_pc4        = pc4;
    case (state_q)
      BOOT: begin
        bus.pc_write = 1'b1;
        if (bus.redirect_valid) bus.next_pc = bus.redirect_target;
      end
      REQ: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          bus.pc_write = 1'b1;
          if (bus.redirect_valid) bus.next_pc = bus.redirect_target;
          else if (pend_q)        bus.next_pc = pend_target_q;
          ld_load = keep && !bus.id_stall;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          bus.pc_write = 1'b1;
          bus.next_pc  = bus.redirect_target;
        end
        ld_instr = skid_instr_q;
        ld_pc4   = skid_pc4_q;
        ld_load  = !bus.id_stall;
      end
      default: ;
    endcase
    if (rst) begin
      bus.imem_req = 1'b0;
      bus.pc_write = 1'b0;
    end
  end

  if_id_latch u_if_id (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.redirect_valid),
    .load_i  (ld_load),
    .hold_i  (bus.id_stall),
    .instr_i (ld_instr),
    .pc4_i   (ld_pc4),
    .instr_o (bus.ifid_instr),
    .pc4_o   (bus.ifid_pc4),
    .valid_o (bus.ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (keep) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (((state_q == REQ) && !bus.imem_ack) || (state_q == HOLD))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
